uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side partner of the team's UART transmit path.
- Single system clock. Oversample tick is generated internally from ClockRate/BaudRate, so no derived clock is used.
- Synchronises and deserialises the line, checks the start and stop bits, and emits one-cycle strobes for a good byte or a frame error.

Parameters:
- ClockRate, 10000000, system clock frequency in Hz.
- BaudRate, 9600, line bit rate.
- Oversample, 8, ticks per bit period; must be even and ≥4.
- TickDiv (derived), ClockRate/(BaudRate*Oversample) with integer floor; 130 at defaults; must be ≥1.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Rx  input  1  asynchronous serial line; idle high.
- RxData  output  8  last correctly framed byte.
- RxValid  output  1  one-cycle strobe; RxData is new this cycle.
- FrameError  output  1  one-cycle strobe; stop bit was sampled low.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - RxData=0x00, RxValid=0, FrameError=0, Busy=0.
  - State=IDLE; all counters 0.
  - Synchroniser flops preset to 1 (idle line).
- Reset taken mid-frame aborts the frame silently: no strobe, RxData unchanged from its reset value.
- Input path: two-flop synchroniser on Rx gives RxS. Only RxS is used downstream.
- Tick generator:
  - Counter runs 0..TickDiv-1 and pulses Tick for one cycle at TickDiv-1, then wraps to 0.
  - Cleared to 0 on entry to START so bit sampling aligns to the detected edge.
  - Free-running in every other state.
- TickCnt: counts Ticks within the current bit window; width $clog2(Oversample)+1.
- State machine:
  - IDLE: on RxS==0, go to START and clear tick counter and TickCnt.
  - START: at Tick with TickCnt==Oversample/2-1 (mid start bit):
    - RxS==1: false start, back to IDLE, no strobe.
    - RxS==0: go to DATA with BitIdx=0 and TickCnt=0.
  - DATA: every Oversample Ticks (TickCnt==Oversample-1), shift RxS into the shift register LSB-first (bit BitIdx).
    - After BitIdx==7 is sampled, go to STOP.
  - STOP: after Oversample Ticks, sample RxS.
    - RxS==1: RxData←shift register, pulse RxValid, go to IDLE.
    - RxS==0: pulse FrameError, leave RxData unchanged, go to BREAK.
  - BREAK: wait for RxS==1, then IDLE. A low line is never treated as a new start.
- Timing at defaults (cycles counted from the START-entry cycle):
  - Mid-start sample at 4×130=520.
  - Data bit n sampled at 520+(n+1)×1040.
  - Stop sampled at 9880.
  - Strobe asserts in the cycle after the stop sample.
- Back-to-back frames: IDLE is entered right after the stop sample, so a start edge half a bit later is caught.
- RxValid and FrameError are never asserted together.
- No consumer handshake: a byte not taken on its RxValid cycle is overwritten by the next byte.
- Busy is combinational from state (State != IDLE).

Test Plan:
- Reset held 3 cycles with Rx=1 → all outputs 0, Busy=0. Then hold Rx=1 for 20000 cycles → no strobe.
- Defaults, drive 0x55 8N1 at 1040 cycles/bit → exactly one RxValid, RxData=0x55, about 9881 cycles after the falling edge seen by the FSM. FrameError stays 0.
- Frames 0x00, 0xFF and 0xA5 back-to-back with no idle gap → three RxValid strobes carrying 0x00, 0xFF, 0xA5 in order.
- Rx low pulse of 300 cycles, then high → FSM returns to IDLE after the mid-start check, no strobe. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven low, Rx held low 5000 further cycles → one FrameError strobe, RxData keeps its previous value, Busy stays high until Rx returns high. A following 0x7E frame is received.
- Assert Reset midway through data bit 4 of a 0xC3 frame → no strobe, state IDLE, RxData=0x00. A complete 0x12 frame sent afterwards gives RxValid with 0x12.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal oversample tick generation.
// Emits one-cycle strobes for a correctly framed byte or a frame error.
`timescale 1ns / 1ps

module uart_rx #(
    parameter int unsigned ClockRate  = 10000000,
    parameter int unsigned BaudRate   = 9600,
    parameter int unsigned Oversample = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       FrameError,
    output logic       Busy
);

    localparam int unsigned TickDiv = ClockRate / (BaudRate * Oversample);
    localparam int unsigned DivW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned CntW    = $clog2(Oversample) + 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(TickDiv - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(Oversample / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(Oversample - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [DivW-1:0] div_cnt;
    logic            tick;
    logic [CntW-1:0] tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    // Preset to idle-high so reset never looks like a start edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (div_cnt == DivLast);

    // Restarted on the detected start edge so samples land mid-bit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if ((state == S_IDLE && !rx_s) || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            RxValid    <= 1'b0;
            FrameError <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tick_cnt == HalfLast) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tick_cnt == BitLast) begin
                            tick_cnt           <= '0;
                            shift_reg[bit_idx] <= rx_s;
                            bit_idx            <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= S_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (tick_cnt == BitLast) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                RxData  <= shift_reg;
                                RxValid <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                FrameError <= 1'b1;
                                state      <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written corner sequences.
// Runs at a reduced clock rate so a bit period is 208 cycles instead of 1040.
`timescale 1ns / 1ps

module tb_uart_rx;

    localparam int unsigned ClockRate  = 2000000;
    localparam int unsigned BaudRate   = 9600;
    localparam int unsigned Oversample = 8;
    // 2e6 / (9600 * 8) = 26.04 -> 26 clocks per tick, 208 clocks per bit.
    localparam int unsigned BitCycles  = 208;
    // Drive edge to strobe: 3 (sync + IDLE detect) + 26 * (4 + 9 * 8) = 1979.
    localparam int          ExpLatency = 1979;
    localparam int unsigned GlitchLen  = 52;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Rx    = 1'b1;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FrameError;
    logic       Busy;

    uart_rx #(
        .ClockRate (ClockRate),
        .BaudRate  (BaudRate),
        .Oversample(Oversample)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Rx        (Rx),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .FrameError(FrameError),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int          valid_cnt      = 0;
    int          ferr_cnt       = 0;
    int          both_cnt       = 0;
    int unsigned last_valid_cyc = 0;
    logic [7:0]  last_data      = 8'h00;

    always @(negedge Clock) begin
        if (RxValid) begin
            valid_cnt      = valid_cnt + 1;
            last_valid_cyc = cyc;
            last_data      = RxData;
        end
        if (FrameError) ferr_cnt = ferr_cnt + 1;
        if (RxValid && FrameError) both_cnt = both_cnt + 1;
    end

    int          checks = 0;
    int          errors = 0;
    int unsigned frame_start_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge Clock);
    endtask

    // Leaves Rx at the stop-bit level so a low stop can be held afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        Rx = 1'b0;
        frame_start_cyc = cyc;
        wait_cycles(BitCycles);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            wait_cycles(BitCycles);
        end
        Rx = stop;
        wait_cycles(BitCycles);
    endtask

    typedef struct {
        logic [7:0]  data;
        int unsigned gap;
        int          exp_valid;
        int          exp_ferr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0;
        int         f0;
        logic [7:0] pat;

        vecs[0] = '{data: 8'h55, gap: 300, exp_valid: 1, exp_ferr: 0, exp_data: 8'h55};
        vecs[1] = '{data: 8'h00, gap: 0,   exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
        vecs[2] = '{data: 8'hFF, gap: 0,   exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};
        vecs[3] = '{data: 8'hA5, gap: 300, exp_valid: 1, exp_ferr: 0, exp_data: 8'hA5};

        Reset = 1'b1;
        Rx    = 1'b1;
        wait_cycles(3);
        check("reset_rxdata", RxData, 0);
        check("reset_rxvalid", RxValid, 0);
        check("reset_frameerror", FrameError, 0);
        check("reset_busy", Busy, 0);
        Reset = 1'b0;

        wait_cycles(20000);
        check("idle_no_valid", valid_cnt, 0);
        check("idle_no_ferr", ferr_cnt, 0);
        check("idle_busy", Busy, 0);

        for (int i = 0; i < 4; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, 1'b1);
            Rx = 1'b1;
            wait_cycles(vecs[i].gap);
            check($sformatf("vec%0d_valid_count", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_count", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_strobe_data", i), last_data, vecs[i].exp_data);
            check($sformatf("vec%0d_rxdata", i), RxData, vecs[i].exp_data);
            if (i == 0) begin
                check("vec0_latency", int'(last_valid_cyc - frame_start_cyc), ExpLatency);
            end
        end

        // Short low glitch: rejected at the mid-start check.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        Rx = 1'b0;
        wait_cycles(GlitchLen);
        Rx = 1'b1;
        check("glitch_busy_in_start", Busy, 1);
        wait_cycles(BitCycles);
        check("glitch_busy_after", Busy, 0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        wait_cycles(300);
        check("after_glitch_valid", valid_cnt - v0, 1);
        check("after_glitch_data", RxData, 8'h3C);

        // Low stop bit, line held low: single error strobe, stays busy.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0);
        wait_cycles(5000);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_rxdata_kept", RxData, 8'h3C);
        check("ferr_busy_in_break", Busy, 1);
        Rx = 1'b1;
        wait_cycles(5);
        check("ferr_busy_released", Busy, 0);
        send_frame(8'h7E, 1'b1);
        wait_cycles(300);
        check("after_ferr_valid", valid_cnt - v0, 1);
        check("after_ferr_ferr", ferr_cnt - f0, 1);
        check("after_ferr_data", RxData, 8'h7E);

        // Reset halfway through data bit 4 of 0xC3.
        v0  = valid_cnt;
        f0  = ferr_cnt;
        pat = 8'hC3;
        Rx  = 1'b0;
        wait_cycles(BitCycles);
        for (int i = 0; i < 4; i++) begin
            Rx = pat[i];
            wait_cycles(BitCycles);
        end
        Rx = pat[4];
        wait_cycles(BitCycles / 2);
        check("midreset_busy_before", Busy, 1);
        Reset = 1'b1;
        wait_cycles(3);
        Rx    = 1'b1;
        Reset = 1'b0;
        wait_cycles(1);
        check("midreset_busy", Busy, 0);
        check("midreset_rxdata", RxData, 0);
        wait_cycles(BitCycles * 6);
        check("midreset_no_valid", valid_cnt - v0, 0);
        check("midreset_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h12, 1'b1);
        wait_cycles(300);
        check("after_reset_valid", valid_cnt - v0, 1);
        check("after_reset_data", RxData, 8'h12);
        check("after_reset_strobe_data", last_data, 8'h12);

        check("strobes_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
